branch_predictor: RTL and testbench

- Branch history/target table that feeds fetch with a next-PC prediction.
- Consumes the execute-stage branch comparator result (br_en) to train and to detect mispredictions.
- Sits downstream of the comparator and upstream of the PC mux.
- Direct-mapped: per-entry valid bit, tag, target, and 2-bit saturating counter; registered redirect on mispredict; performance counters.

---
 rtl/branch_predictor.sv | 97 +++++++++
 tb/tb_branch_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch history/target table with registered mispredict redirect
module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic        resolve_is_branch,
    input  logic [31:0] resolve_pc,
    input  logic        br_en,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0] f_tag, r_tag;
    logic                f_hit, r_hit, do_update, actual_taken;
    logic [31:0]         actual_next, pred_next;
    logic [3:0]          unused_pc_bits;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[31:IDX_BITS+2];
    assign r_idx = resolve_pc[IDX_BITS+1:2];
    assign r_tag = resolve_pc[31:IDX_BITS+2];
    assign unused_pc_bits = {fetch_pc[1:0], resolve_pc[1:0]};

    // Fetch reads the table as it stands; updates land at the edge, so no bypass.
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;

    assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign do_update    = resolve_valid && resolve_is_branch;
    assign actual_taken = resolve_is_branch && br_en;
    assign actual_next  = actual_taken ? resolve_target : resolve_pc + 32'd4;
    assign pred_next    = resolve_pred_taken ? resolve_pred_target : resolve_pc + 32'd4;

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (do_update) begin
                branch_count <= branch_count + 32'd1;
                if (r_hit) begin
                    ctr_q[r_idx] <= sat_update(ctr_q[r_idx], br_en);
                    if (br_en)
                        target_q[r_idx] <= resolve_target;
                end else if (br_en) begin
                    // Taken miss always replaces whatever aliased into this slot.
                    valid_q[r_idx]  <= 1'b1;
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= resolve_target;
                    ctr_q[r_idx]    <= 2'b10;
                end
            end
            if (resolve_valid) begin
                mispredict  <= (actual_next != pred_next);
                redirect_pc <= actual_next;
                if (actual_next != pred_next)
                    mispredict_count <= mispredict_count + 32'd1;
            end else begin
                mispredict <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic        resolve_is_branch;
    logic [31:0] resolve_pc;
    logic        br_en;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_mc = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_pc(resolve_pc), .br_en(br_en), .resolve_target(resolve_target),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one resolve for exactly one clock edge, then returns 1 ns after that edge.
    task automatic resolve(input logic isbr, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ppt, input logic [31:0] ptgt);
        resolve_valid       = 1'b1;
        resolve_is_branch   = isbr;
        resolve_pc          = pc;
        br_en               = taken;
        resolve_target      = tgt;
        resolve_pred_taken  = ppt;
        resolve_pred_target = ptgt;
        @(posedge clk); #1;
        resolve_valid = 1'b0;
        if (isbr) exp_bc = exp_bc + 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_pc = 32'h60; #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h64) begin bad++; $display("FAIL reset_pred_target got=%h want=00000064", pred_target); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0h want=0", mispredict); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%h want=0", redirect_pc); end
        total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL reset_branch_count got=%0d want=0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL reset_mispredict_count got=%0d want=0", mispredict_count); end
    endtask

    task automatic test_allocate;
        resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        exp_mc = exp_mc + 1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%0h want=1", mispredict); end
        total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL alloc_redirect got=%h want=00000080", redirect_pc); end
        total++; if (mispredict_count !== 32'd1) begin bad++; $display("FAIL alloc_mispredict_count got=%0d want=1", mispredict_count); end
        total++; if (branch_count !== 32'd1) begin bad++; $display("FAIL alloc_branch_count got=%0d want=1", branch_count); end
        fetch_pc = 32'h100; #1;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pred_taken got=%0h want=1", pred_taken); end
        total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL alloc_pred_target got=%h want=00000080", pred_target); end
        @(posedge clk); #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL alloc_pulse_end got=%0h want=0", mispredict); end
    endtask

    task automatic test_counter;
        logic exp_taken [5];
        exp_taken[0] = 1'b0; exp_taken[1] = 1'b1; exp_taken[2] = 1'b1;
        exp_taken[3] = 1'b1; exp_taken[4] = 1'b1;
        fetch_pc = 32'h100;
        // 10 -> 01 with a predicted-taken instruction: redirect to fall-through
        resolve(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        exp_mc = exp_mc + 1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL ctr_nt_mispredict got=%0h want=1", mispredict); end
        total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL ctr_nt_redirect got=%h want=00000104", redirect_pc); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_wnt_pred got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL ctr_wnt_target got=%h want=00000104", pred_target); end
        resolve(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL ctr_nt2_mispredict got=%0h want=0", mispredict); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_snt_pred got=%0h want=0", pred_taken); end
        // 00 -> 01 -> 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 5; i++) begin
            resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
            exp_mc = exp_mc + 1;
            total++; if (pred_taken !== exp_taken[i]) begin bad++; $display("FAIL ctr_taken_step%0d got=%0h want=%0h", i, pred_taken, exp_taken[i]); end
        end
        resolve(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_sat_dec1 got=%0h want=1", pred_taken); end
        resolve(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_sat_dec2 got=%0h want=0", pred_taken); end
        total++; if (branch_count !== exp_bc) begin bad++; $display("FAIL ctr_branch_count got=%0d want=%0d", branch_count, exp_bc); end
        total++; if (mispredict_count !== exp_mc) begin bad++; $display("FAIL ctr_mispredict_count got=%0d want=%0d", mispredict_count, exp_mc); end
    endtask

    task automatic test_alias;
        resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        exp_mc = exp_mc + 1;
        fetch_pc = 32'h100; #1;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_own_hit got=%0h want=1", pred_taken); end
        fetch_pc = 32'h200; #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_foreign_pred got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h204) begin bad++; $display("FAIL alias_foreign_target got=%h want=00000204", pred_target); end
        resolve(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        exp_mc = exp_mc + 1;
        fetch_pc = 32'h200; #1;
        total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL alias_replace_target got=%h want=00000300", pred_target); end
        fetch_pc = 32'h100; #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted_pred got=%0h want=0", pred_taken); end
    endtask

    task automatic test_same_cycle;
        fetch_pc            = 32'h100;
        resolve_valid       = 1'b1;
        resolve_is_branch   = 1'b1;
        resolve_pc          = 32'h100;
        br_en               = 1'b1;
        resolve_target      = 32'h180;
        resolve_pred_taken  = 1'b0;
        resolve_pred_target = 32'h104;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_old_pred got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL same_cycle_old_target got=%h want=00000104", pred_target); end
        @(posedge clk); #1;
        resolve_valid = 1'b0;
        exp_bc = exp_bc + 1;
        exp_mc = exp_mc + 1;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_cycle_new_pred got=%0h want=1", pred_taken); end
        total++; if (pred_target !== 32'h180) begin bad++; $display("FAIL same_cycle_new_target got=%h want=00000180", pred_target); end
    endtask

    task automatic test_back_to_back;
        resolve(1'b0, 32'h40, 1'b1, 32'h900, 1'b1, 32'h90);
        exp_mc = exp_mc + 1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL b2b_0_mispredict got=%0h want=1", mispredict); end
        total++; if (redirect_pc !== 32'h44) begin bad++; $display("FAIL b2b_0_redirect got=%h want=00000044", redirect_pc); end
        resolve(1'b1, 32'h504, 1'b1, 32'h600, 1'b0, 32'h508);
        exp_mc = exp_mc + 1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL b2b_1_mispredict got=%0h want=1", mispredict); end
        total++; if (redirect_pc !== 32'h600) begin bad++; $display("FAIL b2b_1_redirect got=%h want=00000600", redirect_pc); end
        resolve(1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL b2b_2_mispredict got=%0h want=0", mispredict); end
        total++; if (redirect_pc !== 32'h48) begin bad++; $display("FAIL b2b_2_redirect got=%h want=00000048", redirect_pc); end
        total++; if (branch_count !== exp_bc) begin bad++; $display("FAIL b2b_branch_count got=%0d want=%0d", branch_count, exp_bc); end
        total++; if (mispredict_count !== exp_mc) begin bad++; $display("FAIL b2b_mispredict_count got=%0d want=%0d", mispredict_count, exp_mc); end
        fetch_pc = 32'h40; #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL b2b_nonbranch_nowrite got=%0h want=0", pred_taken); end
        fetch_pc = 32'h504; #1;
        total++; if (pred_target !== 32'h600) begin bad++; $display("FAIL b2b_branch_alloc got=%h want=00000600", pred_target); end
    endtask

    task automatic test_correct;
        resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL correct_mispredict got=%0h want=0", mispredict); end
        total++; if (branch_count !== exp_bc) begin bad++; $display("FAIL correct_branch_count got=%0d want=%0d", branch_count, exp_bc); end
        total++; if (mispredict_count !== exp_mc) begin bad++; $display("FAIL correct_mispredict_count got=%0d want=%0d", mispredict_count, exp_mc); end
        fetch_pc = 32'h100; #1;
        total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL correct_target_update got=%h want=00000080", pred_target); end
    endtask

    task automatic test_reset_with_resolve;
        rst = 1'b1;
        resolve(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        rst = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rstres_mispredict got=%0h want=0", mispredict); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rstres_redirect got=%h want=0", redirect_pc); end
        total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL rstres_branch_count got=%0d want=0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL rstres_mispredict_count got=%0d want=0", mispredict_count); end
        fetch_pc = 32'h100; #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rstres_table_cleared got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL rstres_target got=%h want=00000104", pred_target); end
        @(posedge clk); #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rstres_no_late_pulse got=%0h want=0", mispredict); end
    endtask

    initial begin
        rst                 = 1'b1;
        fetch_pc            = 32'h0;
        resolve_valid       = 1'b0;
        resolve_is_branch   = 1'b0;
        resolve_pc          = 32'h0;
        br_en               = 1'b0;
        resolve_target      = 32'h0;
        resolve_pred_taken  = 1'b0;
        resolve_pred_target = 32'h0;
        test_reset;
        test_allocate;
        test_counter;
        test_alias;
        test_same_cycle;
        test_back_to_back;
        test_correct;
        test_reset_with_resolve;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
